pc_fetch_unit: RTL and testbench

- Fetch-side consumer of the decoder's `next_pc_sel` output.
- Owns the architectural PC and fetches one instruction at a time over an instruction-memory req/ack handshake.
- Presents each fetched instruction to the decoder with a valid/ready handshake.
- Waits for the decoder/execute resolution (`next_pc_sel`, branch outcome, operands), then computes the next PC. Non-speculative, single outstanding fetch.

---
 rtl/pc_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Fetch-side owner of the architectural PC. Fetches one instruction at a
//   time over a req/ack instruction-memory handshake, presents it to the
//   decoder over valid/ready, then waits for the resolution (next_pc_sel,
//   branch outcome, operands) before computing the next PC. Non-speculative,
//   at most one fetch outstanding.
//
//   Optional feature (compile-time macro PC_MISALIGN_TRAP_EN):
//     defined   - a target with bits [1:0] != 0 is replaced by TRAP_VEC and
//                 trap pulses for one cycle after the resolution.
//     undefined - target bits [1:0] are forced to 00, trap is tied to 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   imem_req        fetch request, held until imem_ack
//   imem_addr       fetch address (= pc)
//   imem_ack        fetch response strobe, imem_rdata valid this cycle
//   imem_rdata      fetched instruction word
//   inst_valid      buffered instruction available to the decoder
//   inst_ready      decoder accepts the buffered instruction
//   inst_encoding   buffered instruction word
//   inst_pc         PC of the buffered instruction
//   resolve_valid   resolution inputs valid this cycle
//   next_pc_sel     00 PLUS_4, 01 BRANCH, 10 JAL_IMM, 11 JALR
//   branch_taken    branch condition (BRANCH only)
//   imm             sign-extended immediate
//   rs1_val         rs1 operand (JALR only)
//   pc              architectural PC
//   trap            one-cycle misaligned-target pulse
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        inst_encoding,
    output logic [31:0]        inst_pc,
    input  logic               resolve_valid,
    input  logic [1:0]         next_pc_sel,
    input  logic               branch_taken,
    input  logic signed [31:0] imm,
    input  logic [31:0]        rs1_val,
    output logic [31:0]        pc,
    output logic               trap
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [1:0] SEL_PLUS_4  = 2'b00;
    localparam logic [1:0] SEL_BRANCH  = 2'b01;
    localparam logic [1:0] SEL_JAL_IMM = 2'b10;
    localparam logic [1:0] SEL_JALR    = 2'b11;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        ISSUE   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Low during reset and for the cycle in which reset deasserts, so that
    // imem_req only rises after the first clock edge out of reset and an ack
    // in that first cycle is ignored.
    logic active;

    logic        ack_take;
    logic        resolve_take;
    logic [31:0] raw_target;
    logic [31:0] final_target;
    logic        misaligned;

    // Raw next-PC computation; all sums wrap modulo 2^32.
    function automatic logic [31:0] calc_target(
        input logic [1:0]         sel,
        input logic               taken,
        input logic [31:0]        cur_pc,
        input logic signed [31:0] offs,
        input logic [31:0]        base
    );
        logic [31:0] seq;
        seq = cur_pc + 32'd4;
        case (sel)
            SEL_PLUS_4:  calc_target = seq;
            SEL_BRANCH:  calc_target = taken ? (cur_pc + $unsigned(offs)) : seq;
            SEL_JAL_IMM: calc_target = cur_pc + $unsigned(offs);
            SEL_JALR:    calc_target = (base + $unsigned(offs)) & ~32'h1;
            default:     calc_target = seq;
        endcase
    endfunction

    // Misaligned targets either redirect to the trap vector or get their low
    // bits cleared, depending on whether the trap feature is built in.
    function automatic logic [31:0] align_target(input logic [31:0] t);
        if (t[1:0] != 2'b00 && TRAP_EN)
            align_target = TRAP_VEC;
        else
            align_target = {t[31:2], 2'b00};
    endfunction

    assign ack_take     = (state == FETCH) && active && imem_ack;
    assign resolve_take = (state == RESOLVE) && resolve_valid;

    assign raw_target   = calc_target(next_pc_sel, branch_taken, pc, imm, rs1_val);
    assign misaligned   = (raw_target[1:0] != 2'b00);
    assign final_target = align_target(raw_target);

    assign imem_req   = (state == FETCH) && active;
    assign imem_addr  = pc;
    assign inst_valid = (state == ISSUE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (ack_take)     state_nxt = ISSUE;
            ISSUE:   if (inst_ready)   state_nxt = RESOLVE;
            RESOLVE: if (resolve_take) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Fetch capture / resolution update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active        <= 1'b0;
            pc            <= RESET_PC;
            inst_encoding <= 32'h0;
            inst_pc       <= 32'h0;
            trap          <= 1'b0;
        end else begin
            active <= 1'b1;
            trap   <= TRAP_EN && resolve_take && misaligned;
            if (ack_take) begin
                inst_encoding <= imem_rdata;
                inst_pc       <= pc;
            end
            if (resolve_take) begin
                pc <= final_target;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic               clk = 1'b0;
    logic               rst;
    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic               inst_valid;
    logic               inst_ready;
    logic [31:0]        inst_encoding;
    logic [31:0]        inst_pc;
    logic               resolve_valid;
    logic [1:0]         next_pc_sel;
    logic               branch_taken;
    logic signed [31:0] imm;
    logic [31:0]        rs1_val;
    logic [31:0]        pc;
    logic               trap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_encoding(inst_encoding),
        .inst_pc      (inst_pc),
        .resolve_valid(resolve_valid),
        .next_pc_sel  (next_pc_sel),
        .branch_taken (branch_taken),
        .imm          (imm),
        .rs1_val      (rs1_val),
        .pc           (pc),
        .trap         (trap)
    );

    // Stimulus helpers (no checking). All inputs change on the falling edge.
    task automatic fetch_issue(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
    endtask

    task automatic resolve(input logic [1:0] sel, input logic tk,
                           input logic [31:0] im, input logic [31:0] r1);
        resolve_valid = 1'b1;
        next_pc_sel   = sel;
        branch_taken  = tk;
        imm           = im;
        rs1_val       = r1;
        @(negedge clk);
        resolve_valid = 1'b0;
        next_pc_sel   = 2'b00;
        branch_taken  = 1'b0;
        imm           = 32'h0;
        rs1_val       = 32'h0;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        fetch_issue(32'h0000_0013);
        resolve(2'b11, 1'b0, 32'h0, target);
    endtask

    task automatic test_reset;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
        resolve_valid = 1'b0; next_pc_sel = 2'b00; branch_taken = 1'b0;
        imm = 32'h0; rs1_val = 32'h0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || trap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req=%b valid=%b trap=%b, expected 0 0 0", imem_req, inst_valid, trap);
        end
        n_checks++;
        if (pc !== 32'h0 || imem_addr !== 32'h0 || inst_encoding !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: pc=%h addr=%h enc=%h ipc=%h, expected all 0", pc, imem_addr, inst_encoding, inst_pc);
        end
        // Release reset with a stray ack in the same cycle.
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_req: req=%b, expected 0", imem_req);
        end
        @(negedge clk);
        imem_ack = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%b addr=%h valid=%b, expected 1 0 0", imem_req, imem_addr, inst_valid);
        end
    endtask

    task automatic test_basic_fetch;
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        @(negedge clk);
        imem_ack = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_encoding !== 32'h13 || inst_pc !== 32'h0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_issue: valid=%b enc=%h ipc=%h req=%b, expected 1 13 0 0", inst_valid, inst_encoding, inst_pc, imem_req);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept: valid=%b req=%b, expected 0 0", inst_valid, imem_req);
        end
        resolve(2'b00, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || pc !== 32'h4) begin
            n_fail++;
            $display("FAIL basic_plus4: req=%b addr=%h pc=%h, expected 1 4 4", imem_req, imem_addr, pc);
        end
    endtask

    task automatic test_branch;
        goto_pc(32'h100);
        fetch_issue(32'h0000_0063);
        resolve(2'b01, 1'b1, 32'hFFFF_FFF0, 32'h0);
        n_checks++;
        if (imem_addr !== 32'hF0 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_taken: addr=%h req=%b, expected 000000f0 1", imem_addr, imem_req);
        end
        goto_pc(32'h100);
        fetch_issue(32'h0000_0063);
        resolve(2'b01, 1'b0, 32'hFFFF_FFF0, 32'h0);
        n_checks++;
        if (imem_addr !== 32'h104) begin
            n_fail++;
            $display("FAIL branch_not_taken: addr=%h, expected 00000104", imem_addr);
        end
    endtask

    task automatic test_jal_wrap;
        goto_pc(32'h200);
        fetch_issue(32'h0000_006F);
        resolve(2'b10, 1'b0, 32'h0000_0800, 32'h0);
        n_checks++;
        if (imem_addr !== 32'hA00) begin
            n_fail++;
            $display("FAIL jal_imm: addr=%h, expected 00000a00", imem_addr);
        end
        goto_pc(32'hFFFF_FFFC);
        n_checks++;
        if (pc !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_setup: pc=%h, expected fffffffc", pc);
        end
        fetch_issue(32'h0000_0013);
        resolve(2'b00, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (imem_addr !== 32'h0 || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL plus4_wrap: addr=%h pc=%h, expected 0 0", imem_addr, pc);
        end
    endtask

    task automatic test_jalr;
        fetch_issue(32'h0000_0067);
        resolve(2'b11, 1'b0, 32'h2, 32'h1003);
        n_checks++;
        if (imem_addr !== 32'h1004 || trap !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_aligned: addr=%h trap=%b, expected 00001004 0", imem_addr, trap);
        end
        fetch_issue(32'h0000_0067);
        resolve(2'b11, 1'b0, 32'h2, 32'h1000);
`ifdef PC_MISALIGN_TRAP_EN
        n_checks++;
        if (imem_addr !== 32'h100 || trap !== 1'b1) begin
            n_fail++;
            $display("FAIL jalr_misaligned: addr=%h trap=%b, expected 00000100 1", imem_addr, trap);
        end
`else
        n_checks++;
        if (imem_addr !== 32'h1000 || trap !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_misaligned: addr=%h trap=%b, expected 00001000 0", imem_addr, trap);
        end
`endif
        @(negedge clk);
        n_checks++;
        if (trap !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_one_cycle: trap=%b, expected 0", trap);
        end
    endtask

    task automatic test_stall_ignore;
        logic [31:0] pc_before;
        goto_pc(32'h300);
        pc_before = 32'h300;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b1 || inst_encoding !== 32'hDEAD_BEEF || inst_pc !== 32'h300) begin
            n_fail++;
            $display("FAIL stall_hold: valid=%b enc=%h ipc=%h, expected 1 deadbeef 300", inst_valid, inst_encoding, inst_pc);
        end
        // Resolution during ISSUE must be ignored.
        resolve(2'b10, 1'b0, 32'h40, 32'h0);
        n_checks++;
        if (inst_valid !== 1'b1 || pc !== pc_before || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_resolve: valid=%b pc=%h req=%b, expected 1 %h 0", inst_valid, pc, imem_req, pc_before);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        // Ack during RESOLVE must be ignored.
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        @(negedge clk);
        imem_ack = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0 || inst_encoding !== 32'hDEAD_BEEF || pc !== pc_before) begin
            n_fail++;
            $display("FAIL ignore_ack: valid=%b req=%b enc=%h pc=%h, expected 0 0 deadbeef %h", inst_valid, imem_req, inst_encoding, pc, pc_before);
        end
        resolve(2'b00, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (imem_addr !== 32'h304 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_resume: addr=%h req=%b, expected 00000304 1", imem_addr, imem_req);
        end
    endtask

    task automatic test_reset_mid;
        goto_pc(32'h400);
        fetch_issue(32'h0000_0013);
        n_checks++;
        if (pc !== 32'h400 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_setup: pc=%h valid=%b req=%b, expected 400 0 0", pc, inst_valid, imem_req);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0 || inst_encoding !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b req=%b pc=%h enc=%h, expected 0 0 0 0", inst_valid, imem_req, pc, inst_encoding);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: req=%b, expected 0", imem_req);
        end
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_refetch: req=%b addr=%h valid=%b, expected 1 0 0", imem_req, imem_addr, inst_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_branch();
        test_jal_wrap();
        test_jalr();
        test_stall_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
